// File: rtl/legv8_instr_encoder_if.sv
// legv8_instr_encoder_if: field input channel and instruction-word output
// channel of the LEGv8 instruction encoder, each with valid/ready.
interface legv8_instr_encoder_if #(
    parameter int unsigned ADDR_W = 8
);
    // Field input channel (loader -> encoder)
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        fmt;
    logic [10:0]       opcode;
    logic [4:0]        rd;
    logic [4:0]        rn;
    logic [4:0]        rm;
    logic [5:0]        shamt;
    logic [63:0]       imm;

    // Instruction word output channel (encoder -> instruction memory)
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       instr;
    logic [ADDR_W-1:0] out_addr;
    logic              out_err;

    modport master (
        output in_valid, fmt, opcode, rd, rn, rm, shamt, imm, out_ready,
        input  in_ready, out_valid, instr, out_addr, out_err
    );

    modport slave (
        input  in_valid, fmt, opcode, rd, rn, rm, shamt, imm, out_ready,
        output in_ready, out_valid, instr, out_addr, out_err
    );
endinterface

// File: rtl/legv8_instr_encoder.sv
// legv8_instr_encoder: packs decoded LEGv8 fields into 32-bit instruction words,
// range-checks immediates against their field widths, and tags each word with a
// sequential instruction-memory byte address. Two-stage valid/ready pipeline:
// S1 holds the raw fields, S2 holds the packed word.
// Optional feature macro: ENC_ROUNDTRIP_CHECK_EN (re-extension check + err_count).
module legv8_instr_encoder #(
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned ADDR_W = 8
) (
    input  logic                 clk,
    input  logic                 reset_l,
    input  logic                 clear,
    legv8_instr_encoder_if.slave bus,
    output logic                 err_sticky
`ifdef ENC_ROUNDTRIP_CHECK_EN
    ,
    output logic [7:0]           err_count
`endif
);

    localparam int unsigned CNT_W = ADDR_W - 2;

    localparam logic [2:0] FMT_R  = 3'd0;
    localparam logic [2:0] FMT_I  = 3'd1;
    localparam logic [2:0] FMT_D  = 3'd2;
    localparam logic [2:0] FMT_B  = 3'd3;
    localparam logic [2:0] FMT_CB = 3'd4;

    typedef struct packed {
        logic [2:0]  fmt;
        logic [10:0] opcode;
        logic [4:0]  rd;
        logic [4:0]  rn;
        logic [4:0]  rm;
        logic [5:0]  shamt;
        logic [63:0] imm;
    } fields_t;

    fields_t          s1_q;
    logic             s1_full_q;
    logic             s2_valid_q;
    logic [31:0]      instr_q;
    logic             err_q;
    logic [CNT_W-1:0] cnt_q;
    logic             sticky_q;

    logic             s1_adv_c;
    logic             accept_c;
    logic             out_hs_c;
    logic [31:0]      word_c;
    logic             range_err_c;
    logic             pack_err_c;

    // Handshake qualifiers; clear blocks new input for the cycle it is asserted
    assign out_hs_c = s2_valid_q && bus.out_ready;
    assign s1_adv_c = s1_full_q && (!s2_valid_q || bus.out_ready);
    assign accept_c = bus.in_valid && bus.in_ready;

    assign bus.in_ready  = !clear && (!s1_full_q || s1_adv_c);
    assign bus.out_valid = s2_valid_q;
    assign bus.instr     = instr_q;
    assign bus.out_err   = err_q;
    assign bus.out_addr  = {cnt_q, 2'b00};
    assign err_sticky    = sticky_q;

    // Pack S1 fields by format and flag immediates that do not fit their field
    always_comb begin
        word_c      = '0;
        range_err_c = 1'b0;
        case (s1_q.fmt)
            FMT_R: begin
                word_c = {s1_q.opcode, s1_q.rm, s1_q.shamt, s1_q.rn, s1_q.rd};
            end
            FMT_I: begin
                word_c      = {s1_q.opcode[10:1], s1_q.imm[11:0], s1_q.rn, s1_q.rd};
                range_err_c = |s1_q.imm[63:12];
            end
            FMT_D: begin
                word_c      = {s1_q.opcode, s1_q.imm[8:0], 2'b00, s1_q.rn, s1_q.rd};
                range_err_c = !((&s1_q.imm[63:8]) || !(|s1_q.imm[63:8]));
            end
            FMT_B: begin
                word_c      = {s1_q.opcode[10:5], s1_q.imm[25:0]};
                range_err_c = !((&s1_q.imm[63:25]) || !(|s1_q.imm[63:25]));
            end
            FMT_CB: begin
                word_c      = {s1_q.opcode[10:3], s1_q.imm[18:0], s1_q.rd};
                range_err_c = !((&s1_q.imm[63:18]) || !(|s1_q.imm[63:18]));
            end
            default: begin
                word_c      = '0;
                range_err_c = 1'b1;
            end
        endcase
    end

`ifdef ENC_ROUNDTRIP_CHECK_EN
    logic [63:0] rt_imm_c;
    logic        rt_err_c;
    logic [7:0]  err_cnt_q;

    // Re-extend the packed immediate as the processor would and compare to the source
    always_comb begin
        rt_imm_c = s1_q.imm;
        case (s1_q.fmt)
            FMT_D:   rt_imm_c = {{55{word_c[20]}}, word_c[20:12]};
            FMT_B:   rt_imm_c = {{38{word_c[25]}}, word_c[25:0]};
            FMT_CB:  rt_imm_c = {{45{word_c[23]}}, word_c[23:5]};
            default: rt_imm_c = s1_q.imm;
        endcase
        rt_err_c = (rt_imm_c != s1_q.imm);
    end

    assign pack_err_c = range_err_c | rt_err_c;
    assign err_count  = err_cnt_q;

    // Saturating count of erroneous words handed downstream
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            err_cnt_q <= '0;
        end else if (clear) begin
            err_cnt_q <= '0;
        end else if (out_hs_c && err_q && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end
`else
    assign pack_err_c = range_err_c;
`endif

    // S1: capture raw fields on acceptance, empty when the word moves to S2
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            s1_full_q <= 1'b0;
            s1_q      <= '0;
        end else if (clear) begin
            s1_full_q <= 1'b0;
        end else if (accept_c) begin
            s1_full_q <= 1'b1;
            s1_q      <= '{fmt: bus.fmt, opcode: bus.opcode, rd: bus.rd, rn: bus.rn,
                           rm: bus.rm, shamt: bus.shamt, imm: bus.imm};
        end else if (s1_adv_c) begin
            s1_full_q <= 1'b0;
        end
    end

    // S2: register the packed word; hold it stable while downstream stalls
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            s2_valid_q <= 1'b0;
            instr_q    <= '0;
            err_q      <= 1'b0;
        end else if (clear) begin
            s2_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else if (s1_adv_c) begin
            s2_valid_q <= 1'b1;
            instr_q    <= word_c;
            err_q      <= pack_err_c;
        end else if (out_hs_c) begin
            s2_valid_q <= 1'b0;
        end
    end

    // Word address counter, wrapping after DEPTH words; sticky error flag
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            cnt_q    <= '0;
            sticky_q <= 1'b0;
        end else if (clear) begin
            cnt_q    <= '0;
            sticky_q <= 1'b0;
        end else if (out_hs_c) begin
            cnt_q <= (cnt_q == CNT_W'(DEPTH - 1)) ? '0 : cnt_q + CNT_W'(1);
            if (err_q) begin
                sticky_q <= 1'b1;
            end
        end
    end

endmodule
